// File: rtl/seq_pattern_gen_if.sv
// Control and serial-output bundle for the pattern generator.
// Latency: none, wires only.
// Backpressure: none; the master issues start/abort, the slave drives the serial stream and status.
interface seq_pattern_gen_if #(
    parameter int WIDTH = 16,
    parameter int LEN_W = 5,
    parameter int REP_W = 8,
    parameter int GAP_W = 4
);
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] pattern;
    logic [LEN_W-1:0] length;
    logic [REP_W-1:0] repeats;
    logic [GAP_W-1:0] gap;
    logic             seq_out;
    logic             seq_valid;
    logic             frame_start;
    logic             busy;
    logic             done;

    modport master (
        output start, abort, pattern, length, repeats, gap,
        input  seq_out, seq_valid, frame_start, busy, done
    );

    modport slave (
        input  start, abort, pattern, length, repeats, gap,
        output seq_out, seq_valid, frame_start, busy, done
    );
endinterface

// File: rtl/seq_pattern_gen.sv
// Serial pattern generator: shifts a captured pattern out MSB-first, with repeats and idle gaps between frames.
// Latency: first bit one cycle after start is accepted; done pulses one cycle after the last bit.
// Backpressure: none downstream; start is ignored while busy, abort cancels at the next edge without done.
module seq_pattern_gen #(
    parameter int WIDTH = 16,
    parameter int LEN_W = 5,
    parameter int REP_W = 8,
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    seq_pattern_gen_if.slave bus
);
    localparam int               BIT_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [LEN_W-1:0] WIDTH_L = LEN_W'(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sh_pat;     // pattern captured at start
    logic [BIT_W-1:0] sh_top;     // index of the first (MSB) bit of each frame
    logic [GAP_W-1:0] sh_gap;     // gap length captured at start
    logic [BIT_W-1:0] bit_idx;    // index of the bit currently on seq_out
    logic [REP_W-1:0] frame_cnt;  // frames still to send after the current one
    logic [GAP_W-1:0] gap_cnt;    // gap cycles remaining after the current one

    logic [LEN_W-1:0] eff_len;
    logic [BIT_W-1:0] in_top;
    logic [BIT_W-1:0] nxt_idx;

    // Clamp the requested length to the register width and find its first bit index.
    always_comb begin
        eff_len = ((bus.length == '0) || (bus.length > WIDTH_L)) ? WIDTH_L : bus.length;
        in_top  = BIT_W'(eff_len - LEN_W'(1));
        nxt_idx = bit_idx - BIT_W'(1);
    end

    // Frame sequencer: IDLE -> SHIFT (-> GAP -> SHIFT)* -> IDLE, all outputs registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= ST_IDLE;
            sh_pat          <= '0;
            sh_top          <= '0;
            sh_gap          <= '0;
            bit_idx         <= '0;
            frame_cnt       <= '0;
            gap_cnt         <= '0;
            bus.seq_out     <= 1'b0;
            bus.seq_valid   <= 1'b0;
            bus.frame_start <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
        end else begin
            bus.frame_start <= 1'b0;
            bus.done        <= 1'b0;
            case (state)
                ST_IDLE: begin
                    bus.seq_out   <= 1'b0;
                    bus.seq_valid <= 1'b0;
                    bus.busy      <= 1'b0;
                    if (bus.start && !bus.abort) begin
                        sh_pat          <= bus.pattern;
                        sh_top          <= in_top;
                        sh_gap          <= bus.gap;
                        frame_cnt       <= bus.repeats;
                        bit_idx         <= in_top;
                        bus.seq_out     <= bus.pattern[in_top];
                        bus.seq_valid   <= 1'b1;
                        bus.frame_start <= 1'b1;
                        bus.busy        <= 1'b1;
                        state           <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (bus.abort) begin
                        state         <= ST_IDLE;
                        bus.seq_out   <= 1'b0;
                        bus.seq_valid <= 1'b0;
                        bus.busy      <= 1'b0;
                    end else if (bit_idx == '0) begin
                        if (frame_cnt == '0) begin
                            // Last bit of the last frame: report completion.
                            state         <= ST_IDLE;
                            bus.seq_out   <= 1'b0;
                            bus.seq_valid <= 1'b0;
                            bus.busy      <= 1'b0;
                            bus.done      <= 1'b1;
                        end else begin
                            frame_cnt <= frame_cnt - REP_W'(1);
                            if (sh_gap == '0) begin
                                bit_idx         <= sh_top;
                                bus.seq_out     <= sh_pat[sh_top];
                                bus.frame_start <= 1'b1;
                            end else begin
                                state         <= ST_GAP;
                                gap_cnt       <= sh_gap - GAP_W'(1);
                                bus.seq_out   <= 1'b0;
                                bus.seq_valid <= 1'b0;
                            end
                        end
                    end else begin
                        bit_idx     <= nxt_idx;
                        bus.seq_out <= sh_pat[nxt_idx];
                    end
                end
                ST_GAP: begin
                    if (bus.abort) begin
                        state         <= ST_IDLE;
                        bus.seq_out   <= 1'b0;
                        bus.seq_valid <= 1'b0;
                        bus.busy      <= 1'b0;
                    end else if (gap_cnt == '0) begin
                        state           <= ST_SHIFT;
                        bit_idx         <= sh_top;
                        bus.seq_out     <= sh_pat[sh_top];
                        bus.seq_valid   <= 1'b1;
                        bus.frame_start <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                default: begin
                    // Unreachable encodings recover to a quiet IDLE.
                    state         <= ST_IDLE;
                    bus.seq_out   <= 1'b0;
                    bus.seq_valid <= 1'b0;
                    bus.busy      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_pattern_gen.sv
// Bench for seq_pattern_gen: vector table, directed handshake/abort/reset cases, randomized runs vs a frame model.
// Latency: expects first bit one cycle after start and done one cycle after the last bit.
// Backpressure: none; start/abort are driven directly.
module tb_seq_pattern_gen;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    seq_pattern_gen_if #(.WIDTH(16), .LEN_W(5), .REP_W(8), .GAP_W(4)) bus ();

    seq_pattern_gen #(.WIDTH(16), .LEN_W(5), .REP_W(8), .GAP_W(4)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] pat;
        logic [4:0]  len;
        logic [7:0]  rep;
        logic [3:0]  gap;
        logic [5:0]  n;     // cycles from first bit to last bit
        logic [31:0] bits;  // seq_out per cycle, cycle 1 in bit n-1
        logic [31:0] vld;   // seq_valid per cycle
        logic [31:0] fs;    // frame_start per cycle
        logic [3:0]  hits;  // 1011 detector hits over the valid bits
    } vec_t;

    vec_t tbl [8];

    bit eq_out [$];
    bit eq_vld [$];
    bit eq_fs  [$];

    task automatic chk5(input string name, input logic [4:0] act, input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual={busy,done,fs,vld,out}=%b required=%b", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic logic [4:0] outs();
        return {bus.busy, bus.done, bus.frame_start, bus.seq_valid, bus.seq_out};
    endfunction

    function automatic logic [4:0] mk(input bit b, input bit d, input bit f, input bit v, input bit o);
        return {b, d, f, v, o};
    endfunction

    // Frame-level reference: frames of L bits MSB-first, gap idle cycles between frames.
    task automatic model(input logic [15:0] pat, input int len, input int rep, input int gp,
                         output int hits);
        int   l;
        int   nv;
        logic [3:0] h;
        l = (len == 0 || len > 16) ? 16 : len;
        eq_out.delete(); eq_vld.delete(); eq_fs.delete();
        for (int f = 0; f <= rep; f++) begin
            for (int b = l - 1; b >= 0; b--) begin
                eq_out.push_back(pat[b]);
                eq_vld.push_back(1'b1);
                eq_fs.push_back(b == l - 1);
            end
            if (f < rep)
                for (int g = 0; g < gp; g++) begin
                    eq_out.push_back(1'b0); eq_vld.push_back(1'b0); eq_fs.push_back(1'b0);
                end
        end
        hits = 0; nv = 0; h = 4'b0;
        for (int i = 0; i < eq_out.size(); i++)
            if (eq_vld[i]) begin
                h = {h[2:0], eq_out[i]};
                nv++;
                if (nv >= 4 && h == 4'b1011) hits++;
            end
    endtask

    // Start one transmission, scramble the inputs, and compare every cycle against the expected queues.
    task automatic run_q(input logic [15:0] pat, input logic [4:0] len, input logic [7:0] rep,
                         input logic [3:0] gp, input int exp_hits, input string tag);
        int   hits;
        int   nv;
        logic [3:0] h;
        @(negedge clk);
        bus.pattern = pat; bus.length = len; bus.repeats = rep; bus.gap = gp;
        bus.abort = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.pattern = ~pat; bus.length = len + 5'd3; bus.repeats = ~rep; bus.gap = gp + 4'd1;
        hits = 0; nv = 0; h = 4'b0;
        for (int i = 0; i < eq_out.size(); i++) begin
            if (i > 0) @(negedge clk);
            chk5($sformatf("%s c%0d", tag, i + 1), outs(), mk(1'b1, 1'b0, eq_fs[i], eq_vld[i], eq_out[i]));
            if (bus.seq_valid) begin
                h = {h[2:0], bus.seq_out};
                nv++;
                if (nv >= 4 && h == 4'b1011) hits++;
            end
        end
        @(negedge clk);
        chk5($sformatf("%s done", tag), outs(), mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        chk5($sformatf("%s idle", tag), outs(), 5'b0);
        chki($sformatf("%s hits", tag), hits, exp_hits);
    endtask

    initial begin
        logic [15:0] pb;
        logic [15:0] rpat;
        logic [4:0]  rlen;
        logic [7:0]  rrep;
        logic [3:0]  rgap;
        int          mh;
        int          fs_cnt;
        bit          seen;

        checks = 0; errors = 0;
        reset = 1'b0;
        bus.start = 1'b0; bus.abort = 1'b0;
        bus.pattern = '0; bus.length = '0; bus.repeats = '0; bus.gap = '0;
        repeat (3) @(negedge clk);
        chk5("reset_outs", outs(), 5'b0);
        reset = 1'b1;
        @(negedge clk);
        chk5("idle_after_reset", outs(), 5'b0);

        //             pat       len    rep   gap   n      bits        vld         fs          hits
        tbl[0] = '{16'h000B, 5'd4,  8'd0, 4'd0, 6'd4,  32'h000B, 32'h000F, 32'h0008, 4'd1};
        tbl[1] = '{16'h0005, 5'd3,  8'd2, 4'd2, 6'd13, 32'h14A5, 32'h1CE7, 32'h1084, 4'd2};
        tbl[2] = '{16'h000B, 5'd4,  8'd1, 4'd0, 6'd8,  32'h00BB, 32'h00FF, 32'h0088, 4'd2};
        tbl[3] = '{16'h8001, 5'd0,  8'd0, 4'd0, 6'd16, 32'h8001, 32'hFFFF, 32'h8000, 4'd0};
        tbl[4] = '{16'h8001, 5'd20, 8'd0, 4'd0, 6'd16, 32'h8001, 32'hFFFF, 32'h8000, 4'd0};
        tbl[5] = '{16'h1235, 5'd1,  8'd0, 4'd0, 6'd1,  32'h0001, 32'h0001, 32'h0001, 4'd0};
        tbl[6] = '{16'hA5C3, 5'd16, 8'd0, 4'd0, 6'd16, 32'hA5C3, 32'hFFFF, 32'h8000, 4'd1};
        tbl[7] = '{16'h0002, 5'd2,  8'd2, 4'd1, 6'd8,  32'h0092, 32'h00DB, 32'h0092, 4'd0};

        for (int k = 0; k < 8; k++) begin
            eq_out.delete(); eq_vld.delete(); eq_fs.delete();
            for (int i = int'(tbl[k].n) - 1; i >= 0; i--) begin
                eq_out.push_back(tbl[k].bits[i]);
                eq_vld.push_back(tbl[k].vld[i]);
                eq_fs.push_back(tbl[k].fs[i]);
            end
            run_q(tbl[k].pat, tbl[k].len, tbl[k].rep, tbl[k].gap, int'(tbl[k].hits),
                  $sformatf("vec%0d", k));
        end

        // abort has priority over start in IDLE
        @(negedge clk);
        bus.pattern = 16'h000B; bus.length = 5'd4; bus.repeats = '0; bus.gap = '0;
        bus.start = 1'b1; bus.abort = 1'b1;
        @(negedge clk);
        chk5("abort_beats_start", outs(), 5'b0);
        bus.start = 1'b0; bus.abort = 1'b0;

        // start held high through the whole frame starts one frame only
        pb = 16'h000B;
        @(negedge clk);
        bus.pattern = pb; bus.length = 5'd4; bus.start = 1'b1;
        fs_cnt = 0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (bus.frame_start) fs_cnt++;
            chk5($sformatf("held c%0d", i), outs(), mk(1'b1, 1'b0, i == 1, 1'b1, pb[4 - i]));
            if (i == 4) bus.start = 1'b0;
        end
        @(negedge clk);
        chk5("held done", outs(), mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        chk5("held idle", outs(), 5'b0);
        chki("held frame_starts", fs_cnt, 1);

        // start pulsed while busy is ignored
        @(negedge clk);
        bus.pattern = pb; bus.length = 5'd4; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            if (i > 1) @(negedge clk);
            chk5($sformatf("busystart c%0d", i), outs(), mk(1'b1, 1'b0, i == 1, 1'b1, pb[4 - i]));
            if (i == 2) begin bus.start = 1'b1; bus.pattern = 16'h0000; bus.length = 5'd2; end
            if (i == 3) bus.start = 1'b0;
        end
        @(negedge clk);
        chk5("busystart done", outs(), mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        chk5("busystart idle", outs(), 5'b0);

        // start accepted in the done cycle
        @(negedge clk);
        bus.pattern = pb; bus.length = 5'd4; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 2; i <= 4; i++) @(negedge clk);
        chk5("donestart c4", outs(), mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1));
        @(negedge clk);
        chk5("donestart c5", outs(), mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        bus.pattern = 16'h0003; bus.length = 5'd2; bus.start = 1'b1;
        @(negedge clk);
        chk5("donestart c6", outs(), mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b1));
        bus.start = 1'b0;
        @(negedge clk);
        chk5("donestart c7", outs(), mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1));
        @(negedge clk);
        chk5("donestart c8", outs(), mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0));

        // abort in cycle 3 of a 16-bit frame
        @(negedge clk);
        bus.pattern = 16'hFFFF; bus.length = 5'd0; bus.repeats = 8'd3; bus.gap = 4'd0; bus.start = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            chk5($sformatf("abort c%0d", i), outs(), mk(1'b1, 1'b0, i == 1, 1'b1, 1'b1));
        end
        bus.abort = 1'b1;
        @(negedge clk);
        chk5("abort c4", outs(), 5'b0);
        bus.abort = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy || bus.seq_valid) seen = 1'b1;
        end
        chki("abort quiet after", int'(seen), 0);

        // asynchronous reset in the middle of a gap
        @(negedge clk);
        bus.pattern = 16'h0005; bus.length = 5'd3; bus.repeats = 8'd2; bus.gap = 4'd4; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk5("rstgap c3", outs(), mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1));
        @(negedge clk);
        chk5("rstgap c4", outs(), mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        #2 reset = 1'b0;
        #1 chk5("rstgap async", outs(), 5'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk5("rstgap idle", outs(), 5'b0);

        // randomized configurations against the frame model; first run covers repeats=255
        for (int r = 0; r < 25; r++) begin
            rpat = 16'($urandom);
            if (r == 0) begin
                rlen = 5'd2; rrep = 8'd255; rgap = 4'd0;
            end else begin
                rlen = 5'($urandom_range(0, 20));
                rrep = 8'($urandom_range(0, 3));
                rgap = 4'($urandom_range(0, 3));
            end
            model(rpat, int'(rlen), int'(rrep), int'(rgap), mh);
            run_q(rpat, rlen, rrep, rgap, mh, $sformatf("rnd%0d", r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seq_pattern_gen.md
Name: seq_pattern_gen

Overview:
- Serial bit-stream generator: loads a programmable bit pattern and emits it one bit per clock, MSB-first, with a repeat count and a programmable idle gap between frames.
- Transmit-side counterpart to the team's serial sequence detectors. Its seq_out drives a detector's serial input in system use and as stimulus on benches.
- Control is a start/busy/done handshake with a synchronous abort.

Parameters:
WIDTH, 16, pattern register width in bits (maximum frame length).
LEN_W, 5, width of length input; must hold the value WIDTH.
REP_W, 8, width of repeat count input.
GAP_W, 4, width of inter-frame gap input.

Ports:
clk  input  1  system clock; all state changes on rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
start  input  1  request a transmission; sampled only in IDLE.
abort  input  1  synchronous cancel; stops transmission, no done pulse.
pattern  input  WIDTH  bits to send; the low `length` bits are used.
length  input  LEN_W  frame length in bits; 0 or >WIDTH means WIDTH.
repeats  input  REP_W  extra frames; total frames = repeats+1.
gap  input  GAP_W  idle cycles between frames; 0 means back-to-back.
seq_out  output  1  serial data bit (registered).
seq_valid  output  1  seq_out carries a pattern bit this cycle.
frame_start  output  1  one-cycle pulse coincident with bit 0 of every frame.
busy  output  1  high from the first bit until the last bit of the last frame.
done  output  1  one-cycle pulse after normal completion.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE. seq_out, seq_valid, frame_start, busy and done all 0. Shadow registers and counters are cleared. Reset mid-frame aborts immediately with no done pulse.
- All outputs are registered. Input buses are captured into shadow registers when start is accepted. Later changes to the inputs have no effect until the next start.
- States:
  - IDLE: outputs 0, except done as described below.
  - SHIFT: seq_valid=1, busy=1.
  - GAP: seq_valid=0, seq_out=0, busy=1.
- IDLE -> SHIFT: at the rising edge where start=1 and abort=0. Latency is 1: the first bit appears in the cycle after start is sampled, together with frame_start=1 and busy=1.
- Effective length L = (length==0 || length>WIDTH) ? WIDTH : length.
- Bit order: pattern[L-1] first, down to pattern[0].
  - Example: pattern=16'h000B, L=4 gives 1,0,1,1.
- SHIFT lasts exactly L cycles per frame. After the last bit of a frame:
  - if frames remain and gap>0: go to GAP for exactly gap cycles, then SHIFT with frame_start=1.
  - if frames remain and gap==0: the next frame's bit 0 follows in the very next cycle with frame_start=1.
  - if this was the last frame: go to IDLE. In that next cycle done=1 (one cycle), with busy=0 and seq_valid=0.
- start is ignored while busy=1. start is accepted in the done cycle, since that cycle is IDLE. In that case the first bit appears in the following cycle, together with busy=1.
- abort=1 in SHIFT or GAP: at the next edge go to IDLE with all outputs 0 and no done pulse. abort has priority over start. abort in IDLE has no effect.
- Counters:
  - bit counter: range 0..WIDTH-1.
  - frame counter: REP_W bits, counts down from repeats; the last frame is reached at 0, with no wrap.
  - gap counter: GAP_W bits.
  - repeats at all-ones (255) sends 256 frames; no overflow.
- Illegal state encodings return to IDLE at the next edge with outputs 0.

Test Plan:
- Basic frame: pattern=16'h000B, length=4, repeats=0, gap=0, pulse start. Required: seq_out=1,0,1,1 with seq_valid=1 on cycles 1-4 after start; frame_start on cycle 1; done=1 on cycle 5; busy high on cycles 1-4 only.
- Repeat with gap: pattern=16'h0005, length=3, repeats=2, gap=2. Required: 101, 00 (valid=0), 101, 00, 101; frame_start 3 times; done at cycle 14.
- Back-to-back and detector loop: pattern=16'h000B, length=4, repeats=1, gap=0, with seq_out feeding a 1011 detector. Required: 8 contiguous valid bits 10111011 and two detector hits.
- Length edge cases: length=0 with pattern=16'h8001 sends 16 bits, first and last =1 and others 0. length=20 behaves identically. length=1 with pattern[0]=1 sends a single bit 1.
- Abort and reset: abort in cycle 3 of a 16-bit frame gives all outputs 0 from the next cycle and no done. In a separate run, reset=0 mid-GAP clears outputs immediately (asynchronously).
- Handshake: start held high through a 4-bit frame starts exactly one frame. start pulsed during busy is ignored. start pulsed in the done cycle starts a new frame whose first bit appears in the next cycle.
